// File: rtl/wd_pkg.sv
// Shared types and WatchDogReg field positions for the LPC watchdog.
package wd_pkg;

    // Watchdog controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        EXPIRE = 2'd2
    } wd_state_t;

    // Field positions inside WatchDogReg.
    localparam int unsigned WD_EN_BIT    = 7;
    localparam int unsigned WD_IRQEN_BIT = 6;
    localparam int unsigned WD_TO_MSB    = 5;
    localparam int unsigned WD_TO_LSB    = 0;

    // Timeout field of a WatchDogReg value.
    function automatic logic [5:0] wd_timeout(input logic [7:0] cfg);
        return cfg[WD_TO_MSB:WD_TO_LSB];
    endfunction

endpackage

// File: rtl/wd_prescaler.sv
// Divides LpcClock down to the watchdog tick rate.
// The tick is flagged in the cycle whose closing edge wraps the prescaler to 0.
module wd_prescaler #(
    parameter int unsigned TICK_DIV = 33000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_tick
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("wd_prescaler: TICK_DIV must be >= 2");
    end

    logic [PW-1:0] r_cnt;

    assign o_tick = i_run && (r_cnt == LAST);

    // Free-running modulo-TICK_DIV counter; held at 0 whenever not running.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clear || !i_run) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lpc_watchdog_timer.sv
// Software watchdog driven by the LPC register block: counts down in ticks,
// raises a pre-expiry interrupt, flags expiry and emits a reset-request pulse.
module lpc_watchdog_timer #(
    parameter int unsigned TICK_DIV    = 33000000,
    parameter int unsigned IRQ_LEAD    = 2,
    parameter int unsigned RST_PULSE_W = 16
) (
    input  logic       LpcClock,
    input  logic       PciReset,
    input  logic [7:0] WatchDogReg,
    input  logic       LoadWDTimer,
    input  logic       ClrWdIrq,
    input  logic       ClrWdStatus,
    output logic       WatchDogIREQ,
    output logic       WatchDogOccurred,
    output logic       WdResetReq,
    output logic [5:0] WdCount,
    output logic       WdActive
);

    import wd_pkg::*;

    localparam int unsigned PULSE_W = $clog2(RST_PULSE_W + 1);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RST_PULSE_W - 1);
    localparam logic [5:0] IRQ_LEAD_CNT = 6'(IRQ_LEAD);

    if (RST_PULSE_W < 1) begin : g_bad_pulse_w
        $error("lpc_watchdog_timer: RST_PULSE_W must be >= 1");
    end
    if (IRQ_LEAD > 63) begin : g_bad_irq_lead
        $error("lpc_watchdog_timer: IRQ_LEAD must fit the 6-bit counter");
    end

    // Registered state.
    wd_state_t          r_state;
    logic [5:0]         r_count;
    logic [PULSE_W-1:0] r_pulse;
    logic               r_rst_req;
    logic               r_active;
    logic               r_irq;
    logic               r_occ;

    // Next-state and decoded signals.
    wd_state_t          w_state_nxt;
    logic [5:0]         w_count_nxt;
    logic [PULSE_W-1:0] w_pulse_nxt;
    logic               w_rst_req_nxt;
    logic               w_set_irq;
    logic               w_set_occ;
    logic               w_pre_clear;
    logic               w_pre_run;
    logic               w_tick;
    logic               w_en;
    logic               w_irq_en;
    logic [5:0]         w_load_val;
    logic [5:0]         w_count_dec;

    assign w_en        = WatchDogReg[WD_EN_BIT];
    assign w_irq_en    = WatchDogReg[WD_IRQEN_BIT];
    assign w_load_val  = wd_timeout(WatchDogReg);
    assign w_count_dec = r_count - 6'd1;
    assign w_pre_run   = (r_state == COUNT);

    wd_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .i_clk   (LpcClock),
        .i_rst   (PciReset),
        .i_clear (w_pre_clear),
        .i_run   (w_pre_run),
        .o_tick  (w_tick)
    );

    // Next-state, counter and pulse decode for the watchdog controller.
    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_pulse_nxt   = r_pulse;
        w_rst_req_nxt = 1'b0;
        w_set_irq     = 1'b0;
        w_set_occ     = 1'b0;
        w_pre_clear   = 1'b0;

        unique case (r_state)
            IDLE: begin
                // A zero timeout never arms the timer.
                if (LoadWDTimer && w_en && (w_load_val != 6'd0)) begin
                    w_state_nxt = COUNT;
                    w_count_nxt = w_load_val;
                    w_pre_clear = 1'b1;
                end
            end

            COUNT: begin
                if (!w_en) begin
                    // Disable freezes the count and sets no flags.
                    w_state_nxt = IDLE;
                end else if (LoadWDTimer) begin
                    // A kick wins over a tick landing in the same cycle.
                    w_count_nxt = w_load_val;
                    w_pre_clear = 1'b1;
                    if (w_load_val == 6'd0) begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_tick && (r_count != 6'd0)) begin
                    w_count_nxt = w_count_dec;
                    if (w_irq_en && (w_count_dec == IRQ_LEAD_CNT)) begin
                        w_set_irq = 1'b1;
                    end
                    if (r_count == 6'd1) begin
                        w_state_nxt   = EXPIRE;
                        w_set_occ     = 1'b1;
                        w_pulse_nxt   = '0;
                        w_rst_req_nxt = 1'b1;
                    end
                end
            end

            EXPIRE: begin
                // Loads are ignored here; the pulse always runs to completion.
                if (r_pulse == PULSE_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_pulse_nxt   = r_pulse + 1'b1;
                    w_rst_req_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; flag set beats same-cycle clear.
    always_ff @(posedge LpcClock or posedge PciReset) begin
        if (PciReset) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_pulse   <= '0;
            r_rst_req <= 1'b0;
            r_active  <= 1'b0;
            r_irq     <= 1'b0;
            r_occ     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_pulse   <= w_pulse_nxt;
            r_rst_req <= w_rst_req_nxt;
            r_active  <= (w_state_nxt == COUNT);
            r_irq     <= w_set_irq | (r_irq & ~ClrWdIrq);
            r_occ     <= w_set_occ | (r_occ & ~ClrWdStatus);
        end
    end

    assign WatchDogIREQ     = r_irq;
    assign WatchDogOccurred = r_occ;
    assign WdResetReq       = r_rst_req;
    assign WdCount          = r_count;
    assign WdActive         = r_active;

endmodule

// File: tb/tb_lpc_watchdog_timer.sv
// Directed bench for lpc_watchdog_timer with a short tick (TICK_DIV=4).
module tb_lpc_watchdog_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wdreg = 8'h00;
    logic       load = 1'b0;
    logic       clr_irq = 1'b0;
    logic       clr_st = 1'b0;
    logic       irq;
    logic       occ;
    logic       rst_req;
    logic [5:0] cnt;
    logic       active;

    int errors = 0;
    int checks = 0;

    int         hi;
    int         min_cnt;
    logic       any_occ;
    logic       any_rst;
    logic       any_irq;
    logic       any_act;
    logic       cnt_moved;

    lpc_watchdog_timer #(
        .TICK_DIV    (4),
        .IRQ_LEAD    (2),
        .RST_PULSE_W (16)
    ) dut (
        .LpcClock         (clk),
        .PciReset         (rst),
        .WatchDogReg      (wdreg),
        .LoadWDTimer      (load),
        .ClrWdIrq         (clr_irq),
        .ClrWdStatus      (clr_st),
        .WatchDogIREQ     (irq),
        .WatchDogOccurred (occ),
        .WdResetReq       (rst_req),
        .WdCount          (cnt),
        .WdActive         (active)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        check("rst_irq", {31'd0, irq}, 0);
        check("rst_occ", {31'd0, occ}, 0);
        check("rst_req", {31'd0, rst_req}, 0);
        check("rst_cnt", {26'd0, cnt}, 0);
        check("rst_active", {31'd0, active}, 0);
        rst = 1'b0;
        step();

        // 1: full countdown from 5 with interrupt, expiry and reset pulse
        wdreg = 8'hC5;
        load = 1'b1;
        step();
        load = 1'b0;
        check("t1_cnt5", {26'd0, cnt}, 5);
        check("t1_active", {31'd0, active}, 1);
        repeat (4) step();
        check("t1_cnt4", {26'd0, cnt}, 4);
        check("t1_irq_early", {31'd0, irq}, 0);
        repeat (4) step();
        check("t1_cnt3", {26'd0, cnt}, 3);
        repeat (4) step();
        check("t1_cnt2", {26'd0, cnt}, 2);
        check("t1_irq_set", {31'd0, irq}, 1);
        repeat (4) step();
        check("t1_cnt1", {26'd0, cnt}, 1);
        check("t1_no_occ_yet", {31'd0, occ}, 0);
        repeat (4) step();
        check("t1_cnt0", {26'd0, cnt}, 0);
        check("t1_occ", {31'd0, occ}, 1);
        check("t1_req_start", {31'd0, rst_req}, 1);
        check("t1_inactive", {31'd0, active}, 0);
        hi = 1;
        for (int i = 0; i < 15; i++) begin
            step();
            if (rst_req) hi++;
        end
        check("t1_req_cycles", hi, 16);
        step();
        check("t1_req_end", {31'd0, rst_req}, 0);
        repeat (5) step();
        check("t1_idle_req", {31'd0, rst_req}, 0);
        check("t1_idle_active", {31'd0, active}, 0);
        check("t1_occ_sticky", {31'd0, occ}, 1);
        clr_irq = 1'b1;
        clr_st = 1'b1;
        step();
        clr_irq = 1'b0;
        clr_st = 1'b0;
        check("t1_irq_clr", {31'd0, irq}, 0);
        check("t1_occ_clr", {31'd0, occ}, 0);

        // 2: periodic kicks keep the count at or above 2
        wdreg = 8'h83;
        min_cnt = 63;
        any_occ = 1'b0;
        any_rst = 1'b0;
        any_irq = 1'b0;
        for (int i = 0; i < 100; i++) begin
            load = ((i % 8) == 0);
            step();
            load = 1'b0;
            if (int'(cnt) < min_cnt) min_cnt = int'(cnt);
            any_occ |= occ;
            any_rst |= rst_req;
            any_irq |= irq;
        end
        check("t2_min_cnt", min_cnt, 2);
        check("t2_no_occ", {31'd0, any_occ}, 0);
        check("t2_no_req", {31'd0, any_rst}, 0);
        check("t2_no_irq", {31'd0, any_irq}, 0);
        check("t2_active", {31'd0, active}, 1);

        // 3: disable while counting at 3
        wdreg = 8'h83;
        load = 1'b1;
        step();
        load = 1'b0;
        check("t3_cnt3", {26'd0, cnt}, 3);
        wdreg = 8'h03;
        step();
        check("t3_inactive", {31'd0, active}, 0);
        check("t3_cnt_hold", {26'd0, cnt}, 3);
        any_occ = 1'b0;
        any_rst = 1'b0;
        any_irq = 1'b0;
        any_act = 1'b0;
        cnt_moved = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            any_occ |= occ;
            any_rst |= rst_req;
            any_irq |= irq;
            any_act |= active;
            if (cnt != 6'd3) cnt_moved = 1'b1;
        end
        check("t3_cnt_stable", {31'd0, cnt_moved}, 0);
        check("t3_no_flags", {29'd0, any_occ, any_rst, any_irq}, 0);
        check("t3_stay_idle", {31'd0, any_act}, 0);

        // 4: set beats clear on the interrupt flag; kick leaves it set
        wdreg = 8'hC5;
        load = 1'b1;
        step();
        load = 1'b0;
        check("t4_cnt5", {26'd0, cnt}, 5);
        repeat (12) step();
        check("t4_cnt2", {26'd0, cnt}, 2);
        check("t4_irq", {31'd0, irq}, 1);
        wdreg = 8'hC3;
        load = 1'b1;
        step();
        load = 1'b0;
        check("t4_kick_cnt", {26'd0, cnt}, 3);
        check("t4_kick_keeps_irq", {31'd0, irq}, 1);
        repeat (3) step();
        clr_irq = 1'b1;
        step();
        clr_irq = 1'b0;
        check("t4_tick_cnt2", {26'd0, cnt}, 2);
        check("t4_set_wins", {31'd0, irq}, 1);
        clr_irq = 1'b1;
        step();
        clr_irq = 1'b0;
        check("t4_clr_alone", {31'd0, irq}, 0);

        // 5: kick coincides with the 1->0 tick
        repeat (3) step();
        check("t5_cnt1", {26'd0, cnt}, 1);
        repeat (3) step();
        wdreg = 8'hC4;
        load = 1'b1;
        step();
        load = 1'b0;
        check("t5_reload", {26'd0, cnt}, 4);
        check("t5_no_occ", {31'd0, occ}, 0);
        check("t5_no_req", {31'd0, rst_req}, 0);
        check("t5_active", {31'd0, active}, 1);
        repeat (4) step();
        check("t5_cnt3", {26'd0, cnt}, 3);
        wdreg = 8'h04;
        step();
        check("t5_disabled", {31'd0, active}, 0);
        wdreg = 8'h80;
        load = 1'b1;
        step();
        load = 1'b0;
        check("t5_zero_load_idle", {31'd0, active}, 0);
        step();
        check("t5_zero_load_idle2", {31'd0, active}, 0);
        check("t5_zero_load_cnt", {26'd0, cnt}, 3);

        // 6: asynchronous reset in the middle of the expiry pulse
        wdreg = 8'hC2;
        load = 1'b1;
        step();
        load = 1'b0;
        check("t6_cnt2", {26'd0, cnt}, 2);
        repeat (8) step();
        check("t6_cnt0", {26'd0, cnt}, 0);
        check("t6_occ", {31'd0, occ}, 1);
        check("t6_req", {31'd0, rst_req}, 1);
        check("t6_no_irq_short_load", {31'd0, irq}, 0);
        repeat (4) step();
        check("t6_req_cycle5", {31'd0, rst_req}, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_req", {31'd0, rst_req}, 0);
        check("t6_async_occ", {31'd0, occ}, 0);
        check("t6_async_cnt", {26'd0, cnt}, 0);
        check("t6_async_active", {31'd0, active}, 0);
        step();
        step();
        rst = 1'b0;
        step();
        check("t6_post_req", {31'd0, rst_req}, 0);
        check("t6_post_active", {31'd0, active}, 0);
        wdreg = 8'hC5;
        load = 1'b1;
        step();
        load = 1'b0;
        check("t6_idle_reload", {26'd0, cnt}, 5);
        check("t6_idle_active", {31'd0, active}, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lpc_watchdog_timer.md
Name: lpc_watchdog_timer

Overview:
- Software watchdog fed by the LPC register block.
- Consumes the watchdog configuration register value and the load/kick strobe decoded from LPC writes.
- Produces the watchdog interrupt request and the watchdog-occurred status that the register block reports back on its inputs.
- Also drives a timed reset-request pulse toward the power/reset sequencer.

Parameters:
- TICK_DIV, 33000000: LpcClock cycles per watchdog tick (1 s at 33 MHz).
- IRQ_LEAD, 2: ticks remaining at which the pre-expiry interrupt fires.
- RST_PULSE_W, 16: width of WdResetReq in LpcClock cycles.

Ports:
- LpcClock, input, 1: 33 MHz LPC clock, the only clock.
- PciReset, input, 1: reset, asynchronous, active-high.
- WatchDogReg, input, 8: configuration.
  - [7] enable.
  - [6] pre-expiry interrupt enable.
  - [5:0] timeout in ticks.
- LoadWDTimer, input, 1: one-cycle strobe that loads/kicks the timer.
- ClrWdIrq, input, 1: one-cycle strobe that clears WatchDogIREQ.
- ClrWdStatus, input, 1: one-cycle strobe that clears WatchDogOccurred.
- WatchDogIREQ, output, 1: sticky pre-expiry interrupt request.
- WatchDogOccurred, output, 1: sticky flag, set on expiry.
- WdResetReq, output, 1: reset request pulse, RST_PULSE_W cycles long.
- WdCount, output, 6: remaining ticks.
- WdActive, output, 1: high in COUNT state.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, prescaler 0, counter 0. Reset is asynchronous and takes effect immediately, including mid-count and mid-pulse.
- FSM states: IDLE, COUNT, EXPIRE.
- IDLE:
  - LoadWDTimer=1 with WatchDogReg[7]=1 and WatchDogReg[5:0]!=0: load counter with [5:0], clear prescaler, go to COUNT next cycle.
  - Any other combination: stay in IDLE.
  - A load value of 0 never starts the timer.
- COUNT:
  - The prescaler counts 0..TICK_DIV-1. A tick occurs in the cycle it wraps to 0, and the counter decrements by 1 on each tick.
  - Kick: LoadWDTimer=1 with enable=1 reloads the counter from WatchDogReg[5:0] and clears the prescaler. This takes priority over a same-cycle tick.
  - Kick with a load value of 0 returns to IDLE.
  - WatchDogReg[7]=0 (sampled every cycle) forces IDLE next cycle. The counter holds its value and no flags are set.
  - Interrupt: when a tick takes the counter to IRQ_LEAD and WatchDogReg[6]=1, set WatchDogIREQ. If the load value is <= IRQ_LEAD, no interrupt is raised for that load.
  - Expiry: when a tick takes the counter from 1 to 0, go to EXPIRE and set WatchDogOccurred in the same edge.
- EXPIRE:
  - WdResetReq=1 for exactly RST_PULSE_W cycles, counted by a pulse counter; then return to IDLE.
  - LoadWDTimer is ignored during EXPIRE.
- Sticky flags:
  - WatchDogIREQ holds until ClrWdIrq.
  - WatchDogOccurred holds until ClrWdStatus.
  - If a set and a clear of the same flag occur in the same cycle, set wins.
  - A kick does not clear WatchDogIREQ.
- Outputs WdCount, WdActive and WdResetReq are registered: exactly 1 cycle from the causing event to the output.
- Widths:
  - Prescaler width is $clog2(TICK_DIV).
  - The counter is 6-bit unsigned and never wraps below 0.
  - TICK_DIV must be >= 2; check with an elaboration assertion.

Decomposition:
- Package wd_pkg contains:
  - wd_state_t enum: IDLE, COUNT, EXPIRE.
  - Bit-position constants WD_EN_BIT=7, WD_IRQEN_BIT=6, WD_TO_MSB=5, WD_TO_LSB=0.
- One sub-module, wd_prescaler.
  - Inputs: clear, run.
  - Output: one-cycle tick.
  - Parameterised by TICK_DIV.

Test Plan (TICK_DIV=4, IRQ_LEAD=2, RST_PULSE_W=16):
1. WatchDogReg=8'hC5, LoadWDTimer pulse:
   - WdCount goes 5,4,3,2 with one step per 4 clocks.
   - WatchDogIREQ rises on the tick to 2.
   - The tick to 0 sets WatchDogOccurred.
   - WdResetReq is high for exactly 16 cycles, then IDLE.
2. WatchDogReg=8'h83, kick every 8 clocks for 100 clocks:
   - WdCount never drops below 2.
   - No WatchDogOccurred, no WdResetReq.
   - WatchDogIREQ=0 (interrupt disabled).
3. In COUNT with WdCount=3, clear WatchDogReg[7]:
   - IDLE next cycle, WdActive=0, WdCount holds 3, no flags for 50 clocks.
4. WatchDogIREQ=1, then ClrWdIrq in the same cycle as a new IRQ_LEAD tick:
   - IREQ stays 1.
   - A later ClrWdIrq alone returns it to 0.
5. Load and tick coincide with WdCount=1:
   - Counter reloads to the new value and no expiry occurs.
   - Also: a load with WatchDogReg=8'h80 stays in IDLE.
6. Assert PciReset during EXPIRE at cycle 5 of the pulse:
   - WdResetReq, WdCount and the flags go to 0 immediately (asynchronously).
   - FSM is in IDLE after reset releases.
